// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single DataMem port.
// Define DMEM_ARB_RR_EN for round-robin; fixed priority (master 0) otherwise.
module dmem_arbiter #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0Req,
    output logic                 m0Ack,
    input  logic [addrWidth-1:0] m0Addr,
    input  logic [dataWidth-1:0] m0Wdata,
    input  logic [2:0]           m0MemOp,
    input  logic                 m0We,
    output logic                 m0Rvalid,
    output logic [dataWidth-1:0] m0Rdata,
    input  logic                 m1Req,
    output logic                 m1Ack,
    input  logic [addrWidth-1:0] m1Addr,
    input  logic [dataWidth-1:0] m1Wdata,
    input  logic [2:0]           m1MemOp,
    input  logic                 m1We,
    output logic                 m1Rvalid,
    output logic [dataWidth-1:0] m1Rdata,
    output logic [addrWidth-1:0] memAddr,
    output logic [dataWidth-1:0] memDin,
    output logic [2:0]           memOp,
    output logic                 memWe,
    input  logic [dataWidth-1:0] memDout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    logic   owner;
    logic   pri0;
    logic   grant0;
    logic   grant1;

`ifdef DMEM_ARB_RR_EN
    logic lastGrant;

    // Remember the most recent winner so the other master wins the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= 1'b1;
        end else if (grant0) begin
            lastGrant <= 1'b0;
        end else if (grant1) begin
            lastGrant <= 1'b1;
        end
    end

    assign pri0 = lastGrant;
`else
    assign pri0 = 1'b1;
`endif

    // Grants are only possible in IDLE; loser keeps its request pending
    always_comb begin
        grant0 = (state == IDLE) && m0Req && (!m1Req || pri0);
        grant1 = (state == IDLE) && m1Req && !grant0;
    end

    assign m0Ack = grant0;
    assign m1Ack = grant1;

    // Sequencer: latch winner, issue for one cycle, hold address for read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            memAddr  <= '0;
            memDin   <= '0;
            memOp    <= '0;
            memWe    <= 1'b0;
            m0Rvalid <= 1'b0;
            m1Rvalid <= 1'b0;
            m0Rdata  <= '0;
            m1Rdata  <= '0;
        end else begin
            m0Rvalid <= 1'b0;
            m1Rvalid <= 1'b0;
            memWe    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner   <= grant1;
                        memAddr <= grant1 ? m1Addr : m0Addr;
                        memDin  <= grant1 ? m1Wdata : m0Wdata;
                        memOp   <= grant1 ? m1MemOp : m0MemOp;
                        memWe   <= grant1 ? m1We : m0We;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // memWe mirrors the latched direction during ISSUE
                    state <= memWe ? IDLE : RESP;
                end
                RESP: begin
                    if (owner) begin
                        m1Rdata  <= memDout;
                        m1Rvalid <= 1'b1;
                    end else begin
                        m0Rdata  <= memDout;
                        m0Rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0Req, m0Ack, m0We, m0Rvalid;
    logic [31:0] m0Addr, m0Wdata, m0Rdata;
    logic [2:0]  m0MemOp;
    logic        m1Req, m1Ack, m1We, m1Rvalid;
    logic [31:0] m1Addr, m1Wdata, m1Rdata;
    logic [2:0]  m1MemOp;
    logic [31:0] memAddr, memDin, memDout;
    logic [2:0]  memOp;
    logic        memWe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q0[$];
    rsp_t        q1[$];
    logic [31:0] shadow[16];
    logic [31:0] mem[16];
    logic [2:0]  ops[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    dmem_arbiter #(.addrWidth(32), .dataWidth(32)) dut (
        .clk(clk), .rst(rst),
        .m0Req(m0Req), .m0Ack(m0Ack), .m0Addr(m0Addr), .m0Wdata(m0Wdata),
        .m0MemOp(m0MemOp), .m0We(m0We), .m0Rvalid(m0Rvalid), .m0Rdata(m0Rdata),
        .m1Req(m1Req), .m1Ack(m1Ack), .m1Addr(m1Addr), .m1Wdata(m1Wdata),
        .m1MemOp(m1MemOp), .m1We(m1We), .m1Rvalid(m1Rvalid), .m1Rdata(m1Rdata),
        .memAddr(memAddr), .memDin(memDin), .memOp(memOp), .memWe(memWe),
        .memDout(memDout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-organised DataMem stand-in: combinational read, clocked write
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hDEADBEEF + 32'(i);
        end else if (memWe) begin
            mem[memAddr[5:2]] <= memDin;
        end
    end

    assign memDout = mem[memAddr[5:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0Req = 0; m0Addr = 0; m0Wdata = 0; m0MemOp = 0; m0We = 0;
        m1Req = 0; m1Addr = 0; m1Wdata = 0; m1MemOp = 0; m1We = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0Req = 1; m1Req = 1;
        @(posedge clk);
        #1;
        checks++;
        if ({memAddr, memDin, memOp, memWe} !== 68'd0) begin
            errors++;
            $display("FAIL reset_mem got %h/%h/%0d/%b want 0", memAddr, memDin, memOp, memWe);
        end
        checks++;
        if ({m0Rvalid, m1Rvalid, m0Rdata, m1Rdata} !== 66'd0) begin
            errors++;
            $display("FAIL reset_resp got %b %b %h %h want 0", m0Rvalid, m1Rvalid, m0Rdata, m1Rdata);
        end
        do_reset();
        m1Req = 1; m1Addr = 32'h4;
        @(negedge clk);
        checks++;
        if ({m0Ack, m1Ack} !== 2'b01) begin
            errors++;
            $display("FAIL reset_lone_m1 got %b%b want 01", m0Ack, m1Ack);
        end
        tick();
        m1Req = 0;
        repeat (3) tick();
    endtask

    task automatic test_load();
        do_reset();
        m0Req = 1; m0Addr = 32'h100; m0MemOp = 3'd2; m0We = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (m0Ack !== (k == 0)) begin
                errors++;
                $display("FAIL load_ack k=%0d got %b want %b", k, m0Ack, k == 0);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (memAddr !== 32'h100 || memWe !== 1'b0 || memOp !== 3'd2) begin
                    errors++;
                    $display("FAIL load_hold k=%0d got %h/%b/%0d want 100/0/2", k, memAddr, memWe, memOp);
                end
            end
            checks++;
            if (m0Rvalid !== (k == 3) || m1Rvalid !== 1'b0) begin
                errors++;
                $display("FAIL load_rvalid k=%0d got %b%b want %b0", k, m0Rvalid, m1Rvalid, k == 3);
            end
            if (k >= 3) begin
                checks++;
                if (m0Rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL load_rdata k=%0d got %h want deadbeef", k, m0Rdata);
                end
            end
            tick();
            m0Req = 0;
        end
    endtask

    task automatic test_store();
        do_reset();
        m1Req = 1; m1Addr = 32'h203; m1Wdata = 32'hA5; m1MemOp = 3'd0; m1We = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (m1Ack !== (k == 0 || k == 2)) begin
                errors++;
                $display("FAIL store_ack k=%0d got %b want %b", k, m1Ack, k == 0 || k == 2);
            end
            checks++;
            if (memWe !== (k == 1 || k == 3)) begin
                errors++;
                $display("FAIL store_we k=%0d got %b want %b", k, memWe, k == 1 || k == 3);
            end
            if (k == 1) begin
                checks++;
                if (memAddr !== 32'h203 || memDin !== 32'hA5 || memOp !== 3'd0) begin
                    errors++;
                    $display("FAIL store_bus got %h/%h/%0d want 203/a5/0", memAddr, memDin, memOp);
                end
            end
            checks++;
            if (m0Rvalid !== 1'b0 || m1Rvalid !== 1'b0) begin
                errors++;
                $display("FAIL store_rvalid k=%0d got %b%b want 00", k, m0Rvalid, m1Rvalid);
            end
            tick();
            if (k == 2) m1Req = 0;
        end
    endtask

    task automatic test_contention();
        logic w;
        logic [1:0] g[3];
        do_reset();
        m0Req = 1; m0Addr = 32'h8; m0MemOp = 3'd2; m0We = 0;
        m1Req = 1; m1Addr = 32'hC; m1MemOp = 3'd2; m1We = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) m0Req = 0;
`ifdef DMEM_ARB_RR_EN
            w = ((k / 3) % 2) == 1;
`else
            w = 1'b0;
`endif
            if (k == 9) w = 1'b1;
            if (k < 9) g[k / 3] = {1'b1, w};
            @(negedge clk);
            checks++;
            if (k % 3 == 0 && {m1Ack, m0Ack} !== (w ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL cont_ack k=%0d got %b%b want owner %0d", k, m1Ack, m0Ack, w);
            end else if (k % 3 != 0 && {m1Ack, m0Ack} !== 2'b00) begin
                errors++;
                $display("FAIL cont_noack k=%0d got %b%b want 00", k, m1Ack, m0Ack);
            end
            if (k >= 3 && k % 3 == 0) begin
                checks++;
                if (g[k / 3 - 1][0]) begin
                    if (m1Rvalid !== 1'b1 || m0Rvalid !== 1'b0 || m1Rdata !== 32'hDEADBEF2) begin
                        errors++;
                        $display("FAIL cont_rv1 k=%0d got %b%b %h want 10 deadbef2", k, m1Rvalid, m0Rvalid, m1Rdata);
                    end
                end else begin
                    if (m0Rvalid !== 1'b1 || m1Rvalid !== 1'b0 || m0Rdata !== 32'hDEADBEF1) begin
                        errors++;
                        $display("FAIL cont_rv0 k=%0d got %b%b %h want 01 deadbef1", k, m1Rvalid, m0Rvalid, m0Rdata);
                    end
                end
            end
            tick();
        end
        m1Req = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0Req = 1; m0Addr = 32'h0; m0MemOp = 3'd2; m0We = 0;
        @(negedge clk);
        checks++;
        if (m0Ack !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ack got %b want 1", m0Ack);
        end
        tick();
        m0Req = 0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (memAddr !== 0 || memWe !== 0 || m0Rvalid !== 0 || m0Rdata !== 0) begin
            errors++;
            $display("FAIL rmid_clear got %h %b %b %h want 0", memAddr, memWe, m0Rvalid, m0Rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m1Req = 1; m1Addr = 32'h4; m1MemOp = 3'd2; m1We = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (m1Ack !== (k == 0) || m0Rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_after k=%0d got ack %b rv0 %b want %b 0", k, m1Ack, m0Rvalid, k == 0);
            end
            if (k == 3) begin
                checks++;
                if (m1Rvalid !== 1'b1 || m1Rdata !== 32'hDEADBEF0) begin
                    errors++;
                    $display("FAIL rmid_m1 got %b %h want 1 deadbef0", m1Rvalid, m1Rdata);
                end
            end
            tick();
            m1Req = 0;
        end
        m0Req = 1; m0Addr = 32'h8; m0Wdata = 32'h55; m0We = 1;
        @(negedge clk);
        tick();
        m0Req = 0;
        @(negedge clk);
        checks++;
        if (memWe !== 1'b1) begin
            errors++;
            $display("FAIL rcut_issue got %b want 1", memWe);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (memWe !== 1'b0) begin
            errors++;
            $display("FAIL rcut_we got %b want 0", memWe);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_pending();
        do_reset();
        m0Req = 1; m0Addr = 32'h44; m0Wdata = 32'h12345678; m0MemOp = 3'd2; m0We = 1;
        m1Req = 1; m1Addr = 32'h44; m1MemOp = 3'd2; m1We = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (m0Ack !== (k == 0) || m1Ack !== (k == 2)) begin
                errors++;
                $display("FAIL pend_ack k=%0d got %b%b want %b%b", k, m0Ack, m1Ack, k == 0, k == 2);
            end
            checks++;
            if (memWe !== (k == 1)) begin
                errors++;
                $display("FAIL pend_we k=%0d got %b want %b", k, memWe, k == 1);
            end
            checks++;
            if (m1Rvalid !== (k == 5) || m0Rvalid !== 1'b0) begin
                errors++;
                $display("FAIL pend_rv k=%0d got %b%b want %b0", k, m1Rvalid, m0Rvalid, k == 5);
            end
            if (k == 5) begin
                checks++;
                if (m1Rdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL pend_data got %h want 12345678", m1Rdata);
                end
            end
            tick();
            m0Req = 0;
            if (k >= 2) m1Req = 0;
        end
    endtask

    task automatic test_random();
        int   nextFree, issueCyc, t;
        logic issueWe, lastG, hs0, hs1, ea0, ea1, pri0, erv;
        logic [31:0] issueAddr;
        rsp_t r;
        do_reset();
        for (int i = 0; i < 16; i++) shadow[i] = 32'hDEADBEEF + 32'(i);
        q0.delete();
        q1.delete();
        nextFree = cyc; issueCyc = -10; issueWe = 0; issueAddr = 0;
        lastG = 1; hs0 = 0; hs1 = 0;
        for (int k = 0; k < 600; k++) begin
            if (hs0) begin m0Req = 0; hs0 = 0; end
            if (hs1) begin m1Req = 0; hs1 = 0; end
            if (k < 590 && !m0Req && $urandom_range(0, 2) == 0) begin
                m0Req = 1; m0Addr = $urandom; m0Wdata = $urandom;
                m0MemOp = ops[$urandom_range(0, 4)]; m0We = 1'($urandom_range(0, 1));
            end
            if (k < 590 && !m1Req && $urandom_range(0, 2) == 0) begin
                m1Req = 1; m1Addr = $urandom; m1Wdata = $urandom;
                m1MemOp = ops[$urandom_range(0, 4)]; m1We = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            t = cyc;
`ifdef DMEM_ARB_RR_EN
            pri0 = lastG;
`else
            pri0 = 1'b1;
`endif
            ea0 = (t >= nextFree) && m0Req && (!m1Req || pri0);
            ea1 = (t >= nextFree) && m1Req && !ea0;
            checks++;
            if (m0Ack !== ea0 || m1Ack !== ea1) begin
                errors++;
                $display("FAIL rnd_ack t=%0d got %b%b want %b%b", t, m0Ack, m1Ack, ea0, ea1);
            end
            checks++;
            if (memWe !== (t == issueCyc && issueWe)) begin
                errors++;
                $display("FAIL rnd_we t=%0d got %b want %b", t, memWe, t == issueCyc && issueWe);
            end
            if (t == issueCyc || (t == issueCyc + 1 && !issueWe)) begin
                checks++;
                if (memAddr !== issueAddr) begin
                    errors++;
                    $display("FAIL rnd_addr t=%0d got %h want %h", t, memAddr, issueAddr);
                end
            end
            erv = q0.size() > 0 && q0[0].due == t;
            checks++;
            if (m0Rvalid !== erv || (erv && m0Rdata !== q0[0].data)) begin
                errors++;
                $display("FAIL rnd_rv0 t=%0d got %b %h want %b", t, m0Rvalid, m0Rdata, erv);
            end
            if (erv) void'(q0.pop_front());
            erv = q1.size() > 0 && q1[0].due == t;
            checks++;
            if (m1Rvalid !== erv || (erv && m1Rdata !== q1[0].data)) begin
                errors++;
                $display("FAIL rnd_rv1 t=%0d got %b %h want %b", t, m1Rvalid, m1Rdata, erv);
            end
            if (erv) void'(q1.pop_front());
            if (ea0 || ea1) begin
                lastG = ea1;
                issueCyc = t + 1;
                issueWe = ea1 ? m1We : m0We;
                issueAddr = ea1 ? m1Addr : m0Addr;
                if (issueWe) begin
                    shadow[issueAddr[5:2]] = ea1 ? m1Wdata : m0Wdata;
                    nextFree = t + 2;
                end else begin
                    r.due = t + 3;
                    r.data = shadow[issueAddr[5:2]];
                    if (ea1) q1.push_back(r);
                    else q0.push_back(r);
                    nextFree = t + 3;
                end
            end
            hs0 = m0Req && m0Ack;
            hs1 = m1Req && m1Ack;
            tick();
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain got %0d/%0d pending want 0", q0.size(), q1.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        m0Req = 0; m0Addr = 0; m0Wdata = 0; m0MemOp = 0; m0We = 0;
        m1Req = 0; m1Addr = 0; m1Wdata = 0; m1MemOp = 0; m1We = 0;
        test_reset();
        test_load();
        test_store();
        test_contention();
        test_reset_mid();
        test_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
